display_sequencer: RTL

- Pixel-clock-domain controller that sequences the HDMI video path from PLL lock to live picture.
- Holds the display timing generator in reset until lock is stable, then releases it. Outputs black for a set number of frames, then enables video.
- Arbitrates frame-aligned test-pattern switch requests with a req/ack handshake.
- Restarts the sequence on lock loss or a missing-frame watchdog timeout.
- Sits between the clocking, the timing generator and the test-pattern/HDMI encoder.

---
 rtl/display_seq_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/display_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/display_seq_pkg.sv
// Shared definitions for the display power-up sequencer.
//   seq_state_e : sequencer state encoding, exported on o_state for debug
//   cnt_w()     : counter width able to hold the values 0 .. max_count-1
package display_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_START  = 3'd1,
        ST_BLACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ARM    = 3'd4,
        ST_BLANK  = 3'd5
    } seq_state_e;

    // Width for a counter that runs 0 .. max_count-1 (never narrower than 1 bit)
    function automatic int unsigned cnt_w(input int unsigned max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
//   clk, rst_n : destination clock and async active-low reset
//   d          : asynchronous input
//   q          : synchronised output
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Brings the HDMI video path up from PLL lock to live picture, arbitrates
// frame-aligned test-pattern switches and restarts on lock loss or frame timeout.
//   i_clk, i_reset_n : pixel clock, async active-low reset
//   i_pll_lock       : PLL lock (asynchronous, synchronised here)
//   i_frame_start    : one-cycle pulse at the first pixel of every frame
//   i_pattern_req/sel: level request for a new test pattern, held until ack
//   o_timing_reset   : reset to the timing generator
//   o_video_enable   : 0 forces RGB black while sync keeps running
//   o_pattern_sel    : pattern currently shown
//   o_pattern_ack    : one-cycle pulse when the requested pattern takes effect
//   o_state          : sequencer state (debug)
//   o_timeout_err    : sticky frame watchdog error
module display_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned BLACK_FRAMES        = 2,
    parameter int unsigned SWITCH_BLANK_FRAMES = 1,
    parameter int unsigned FRAME_TIMEOUT       = 500000,
    parameter int unsigned SEL_W               = 3,
    parameter int unsigned DEFAULT_PATTERN     = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pll_lock,
    input  logic             i_frame_start,
    input  logic             i_pattern_req,
    input  logic [SEL_W-1:0] i_pattern_sel,
    output logic             o_timing_reset,
    output logic             o_video_enable,
    output logic [SEL_W-1:0] o_pattern_sel,
    output logic             o_pattern_ack,
    output logic [2:0]       o_state,
    output logic             o_timeout_err
);
    import display_seq_pkg::*;

    localparam int unsigned LOCK_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int unsigned FRM_W  = cnt_w(max_u(BLACK_FRAMES, SWITCH_BLANK_FRAMES));
    localparam int unsigned WD_W   = cnt_w(FRAME_TIMEOUT);

    logic lock_s;

    seq_state_e        state_q,        state_d;
    logic [LOCK_W-1:0] lock_cnt_q,     lock_cnt_d;
    logic [FRM_W-1:0]  frame_cnt_q,    frame_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q,       wd_cnt_d;
    logic [SEL_W-1:0]  pending_q,      pending_d;
    logic              req_armed_q,    req_armed_d;
    logic              timing_reset_q, timing_reset_d;
    logic              video_en_q,     video_en_d;
    logic [SEL_W-1:0]  pattern_sel_q,  pattern_sel_d;
    logic              pattern_ack_q,  pattern_ack_d;
    logic              timeout_err_q,  timeout_err_d;
    logic              wd_fire;

    sync_2ff u_lock_sync (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .d     (i_pll_lock),
        .q     (lock_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        lock_cnt_d     = lock_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        wd_cnt_d       = wd_cnt_q;
        pending_d      = pending_q;
        // A held request must be seen low after its ack before it can be taken again
        req_armed_d    = req_armed_q | ~i_pattern_req;
        timing_reset_d = timing_reset_q;
        video_en_d     = video_en_q;
        pattern_sel_d  = pattern_sel_q;
        pattern_ack_d  = 1'b0;
        timeout_err_d  = timeout_err_q;

        wd_fire = (state_q != ST_HOLD) && (wd_cnt_q == WD_W'(FRAME_TIMEOUT - 1));

        if (!lock_s || wd_fire) begin
            // Lock loss outranks the watchdog; either restarts the whole bring-up
            state_d        = ST_HOLD;
            lock_cnt_d     = '0;
            frame_cnt_d    = '0;
            wd_cnt_d       = '0;
            timing_reset_d = 1'b1;
            video_en_d     = 1'b0;
            if (lock_s) begin
                timeout_err_d = 1'b1;
            end
        end else begin
            if (state_q != ST_HOLD) begin
                wd_cnt_d = i_frame_start ? '0 : wd_cnt_q + WD_W'(1);
            end

            case (state_q)
                ST_HOLD: begin
                    wd_cnt_d = '0;
                    if (lock_cnt_q == LOCK_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d        = ST_START;
                        lock_cnt_d     = '0;
                        timing_reset_d = 1'b0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end
                ST_START: begin
                    if (i_frame_start) begin
                        if (BLACK_FRAMES <= 1) begin
                            state_d     = ST_ACTIVE;
                            frame_cnt_d = '0;
                            video_en_d  = 1'b1;
                        end else begin
                            state_d     = ST_BLACK;
                            frame_cnt_d = FRM_W'(1);
                        end
                    end
                end
                ST_BLACK: begin
                    if (i_frame_start) begin
                        if (frame_cnt_q == FRM_W'(BLACK_FRAMES - 1)) begin
                            state_d     = ST_ACTIVE;
                            frame_cnt_d = '0;
                            video_en_d  = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRM_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (i_pattern_req && req_armed_q) begin
                        pending_d = i_pattern_sel;
                        state_d   = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (i_frame_start) begin
                        pattern_sel_d = pending_q;
                        if ((pending_q == pattern_sel_q) || (SWITCH_BLANK_FRAMES == 0)) begin
                            state_d       = ST_ACTIVE;
                            pattern_ack_d = 1'b1;
                            req_armed_d   = 1'b0;
                        end else begin
                            state_d     = ST_BLANK;
                            frame_cnt_d = '0;
                            video_en_d  = 1'b0;
                        end
                    end
                end
                ST_BLANK: begin
                    if (i_frame_start) begin
                        if (frame_cnt_q == FRM_W'(SWITCH_BLANK_FRAMES - 1)) begin
                            state_d       = ST_ACTIVE;
                            frame_cnt_d   = '0;
                            video_en_d    = 1'b1;
                            pattern_ack_d = 1'b1;
                            req_armed_d   = 1'b0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRM_W'(1);
                        end
                    end
                end
                default: begin
                    state_d        = ST_HOLD;
                    timing_reset_d = 1'b1;
                    video_en_d     = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_HOLD;
            lock_cnt_q     <= '0;
            frame_cnt_q    <= '0;
            wd_cnt_q       <= '0;
            pending_q      <= '0;
            req_armed_q    <= 1'b1;
            timing_reset_q <= 1'b1;
            video_en_q     <= 1'b0;
            pattern_sel_q  <= SEL_W'(DEFAULT_PATTERN);
            pattern_ack_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            pending_q      <= pending_d;
            req_armed_q    <= req_armed_d;
            timing_reset_q <= timing_reset_d;
            video_en_q     <= video_en_d;
            pattern_sel_q  <= pattern_sel_d;
            pattern_ack_q  <= pattern_ack_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign o_timing_reset = timing_reset_q;
    assign o_video_enable = video_en_q;
    assign o_pattern_sel  = pattern_sel_q;
    assign o_pattern_ack  = pattern_ack_q;
    assign o_state        = state_q;
    assign o_timeout_err  = timeout_err_q;

endmodule
